addr_sequencer: RTL and testbench

Parametrised address-sequence generator: the next generation of the team's `nBitCounter`, used to walk sample and coefficient memories in the regression datapath. It keeps that counter's clock-enable semantics and adds:
- programmable base, length, step and direction;
- single-pass or continuous (wrapping) mode;
- a valid/ready handshake toward the consuming memory port;
- start, abort, last and done control.

---
 rtl/addr_sequencer_if.sv | 27 ++
 rtl/addr_sequencer.sv | 146 ++++++++++++++
 tb/tb_addr_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_sequencer_if.sv
// Address handshake bundle between the sequencer and a memory port.
// The sequencer drives addr/idx/last; the consumer answers with ready.
interface addr_sequencer_if #(
  parameter int W = 32
);
  logic [W-1:0] addr;
  logic         addr_valid;
  logic         addr_ready;
  logic [W-1:0] idx;
  logic         last;

  modport master (
    output addr,
    output addr_valid,
    output idx,
    output last,
    input  addr_ready
  );

  modport slave (
    input  addr,
    input  addr_valid,
    input  idx,
    input  last,
    output addr_ready
  );
endinterface

// File: rtl/addr_sequencer.sv
// Programmable address walker: base/len/step/dir, single or wrapping pass,
// valid/ready toward the memory port, with clock enable and abort.
module addr_sequencer #(
  parameter int W      = 32,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              CLR_n,
  input  logic              CE,
  input  logic              start,
  input  logic              abort,
  input  logic [W-1:0]      base,
  input  logic [W-1:0]      len,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  input  logic              cont,
  addr_sequencer_if.master  bus,
  output logic              wrap,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      addr_q, addr_d;
  logic [W-1:0]      idx_q, idx_d;
  logic [W-1:0]      base_q, base_d;
  logic [W-1:0]      len_q, len_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              dir_q, dir_d;
  logic              cont_q, cont_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;

  logic [W-1:0]      step_ext;
  logic [W-1:0]      addr_nx;
  logic              at_end;
  logic              xfer;

  assign step_ext = W'(step_q);
  assign addr_nx  = dir_q ? addr_q - step_ext
                          : addr_q + step_ext;
  assign at_end   = (idx_q == len_q - W'(1));
  assign xfer     = valid_q & bus.addr_ready;

  // Abort wins over every other event, including the DONE exit.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    base_d  = base_q;
    len_d   = len_q;
    step_d  = step_q;
    dir_d   = dir_q;
    cont_d  = cont_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            base_d = base;
            len_d  = len;
            step_d = step;
            dir_d  = dir;
            cont_d = cont;
            if (len == '0) begin
              state_d = DONE;
              valid_d = 1'b0;
            end else begin
              state_d = RUN;
              addr_d  = base;
              idx_d   = '0;
              valid_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            if (!at_end) begin
              idx_d  = idx_q + W'(1);
              addr_d = addr_nx;
            end else if (cont_q) begin
              addr_d = base_q;
              idx_d  = '0;
              wrap_d = 1'b1;
            end else begin
              state_d = DONE;
              valid_d = 1'b0;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!CLR_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      step_q  <= '0;
      dir_q   <= 1'b0;
      cont_q  <= 1'b0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (CE) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      len_q   <= len_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      cont_q  <= cont_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.addr       = addr_q;
  assign bus.addr_valid = valid_q;
  assign bus.idx        = idx_q;
  assign bus.last       = valid_q & at_end;
  assign wrap           = wrap_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);

endmodule

// File: tb/tb_addr_sequencer.sv
// Bench for addr_sequencer: vector table, directed corner sequences,
// and randomized traffic against a position-based reference model.
module tb_addr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        CLR_n, CE, abort;
  logic        start, dir, cont;
  logic [31:0] base, len;
  logic [7:0]  step;
  logic        wrap, busy, done;

  addr_sequencer_if #(.W(32)) bus32 ();

  addr_sequencer #(.W(32), .STEP_W(8)) u_dut (
    .clk   (clk),
    .CLR_n (CLR_n),
    .CE    (CE),
    .start (start),
    .abort (abort),
    .base  (base),
    .len   (len),
    .step  (step),
    .dir   (dir),
    .cont  (cont),
    .bus   (bus32),
    .wrap  (wrap),
    .busy  (busy),
    .done  (done)
  );

  logic       start8, dir8, cont8;
  logic [7:0] base8, len8, step8;
  logic       wrap8, busy8, done8;

  addr_sequencer_if #(.W(8)) bus8 ();

  addr_sequencer #(.W(8), .STEP_W(8)) u_dut8 (
    .clk   (clk),
    .CLR_n (CLR_n),
    .CE    (CE),
    .start (start8),
    .abort (abort),
    .base  (base8),
    .len   (len8),
    .step  (step8),
    .dir   (dir8),
    .cont  (cont8),
    .bus   (bus8),
    .wrap  (wrap8),
    .busy  (busy8),
    .done  (done8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    check({tag, " valid"}, bus32.addr_valid, 1'b0);
    check({tag, " busy"},  busy,             1'b0);
    check({tag, " done"},  done,             1'b0);
    check({tag, " wrap"},  wrap,             1'b0);
    check({tag, " last"},  bus32.last,       1'b0);
  endtask

  typedef struct {
    logic        s, r, c;
    logic        v;
    logic [31:0] a;
    logic        l, d, b;
  } vec_t;

  vec_t tbl[$];

  task automatic pv(input logic s, input logic r, input logic c,
                    input logic v, input logic [31:0] a,
                    input logic l, input logic d, input logic b);
    vec_t t;
    t.s = s; t.r = r; t.c = c;
    t.v = v; t.a = a; t.l = l; t.d = d; t.b = b;
    tbl.push_back(t);
  endtask

  // reference model state
  int          ph;
  int unsigned pos;
  logic [31:0] mb, ml;
  logic [7:0]  ms;
  logic        md, mc, mw;

  initial begin
    int xfers;
    logic [31:0] ea;

    CLR_n = 1'b0; CE = 1'b1; abort = 1'b0;
    start = 1'b0; dir = 1'b0; cont = 1'b0;
    base = '0; len = '0; step = '0;
    bus32.addr_ready = 1'b0;
    start8 = 1'b0; dir8 = 1'b0; cont8 = 1'b0;
    base8 = '0; len8 = '0; step8 = '0;
    bus8.addr_ready = 1'b0;

    tick(); tick();
    CLR_n = 1'b1;
    chk_quiet("rst0");
    check("rst0 addr", bus32.addr, 32'h0);
    check("rst0 idx",  bus32.idx,  32'h0);

    // ---- vector table: single pass, then backpressure / CE freeze
    pv(1,1,1, 1,32'h10,0,0,1);
    pv(0,1,1, 1,32'h14,0,0,1);
    pv(0,1,1, 1,32'h18,0,0,1);
    pv(0,1,1, 1,32'h1C,1,0,1);
    pv(0,1,1, 0,32'h0, 0,1,1);
    pv(0,1,1, 0,32'h0, 0,0,0);
    pv(1,1,1, 1,32'h10,0,0,1);
    pv(0,1,1, 1,32'h14,0,0,1);
    pv(0,0,1, 1,32'h14,0,0,1);
    pv(0,0,1, 1,32'h14,0,0,1);
    pv(0,1,0, 1,32'h14,0,0,1);
    pv(0,1,0, 1,32'h14,0,0,1);
    pv(0,1,0, 1,32'h14,0,0,1);
    pv(0,1,1, 1,32'h18,0,0,1);
    pv(0,1,1, 1,32'h1C,1,0,1);
    pv(0,1,1, 0,32'h0, 0,1,1);
    pv(0,1,0, 0,32'h0, 0,1,1);
    pv(0,1,0, 0,32'h0, 0,1,1);
    pv(0,1,1, 0,32'h0, 0,0,0);

    base = 32'h10; step = 8'd4; len = 32'd4; dir = 1'b0; cont = 1'b0;
    xfers = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].s;
      bus32.addr_ready = tbl[i].r;
      CE = tbl[i].c;
      if (!tbl[i].s && bus32.addr_valid && tbl[i].r && tbl[i].c)
        xfers++;
      tick();
      check($sformatf("tbl%0d valid", i), bus32.addr_valid, tbl[i].v);
      if (tbl[i].v)
        check($sformatf("tbl%0d addr", i), bus32.addr, tbl[i].a);
      check($sformatf("tbl%0d last", i), bus32.last, tbl[i].l);
      check($sformatf("tbl%0d done", i), done, tbl[i].d);
      check($sformatf("tbl%0d busy", i), busy, tbl[i].b);
    end
    start = 1'b0; CE = 1'b1;
    check("tbl xfers", xfers, 8);

    // ---- reset mid-RUN, with CE low so reset must override it
    start = 1'b1; bus32.addr_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("prerst addr", bus32.addr, 32'h14);
    CE = 1'b0; CLR_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet($sformatf("rst%0d", i + 1));
      check($sformatf("rst%0d addr", i + 1), bus32.addr, 32'h0);
      check($sformatf("rst%0d idx", i + 1),  bus32.idx,  32'h0);
    end
    CLR_n = 1'b1; CE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet($sformatf("postrst%0d", i));
    end

    // ---- 8-bit down walk with modulo wrap
    base8 = 8'h02; step8 = 8'd3; len8 = 8'd3; dir8 = 1'b1; cont8 = 1'b0;
    bus8.addr_ready = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("dn a0", bus8.addr, 8'h02);
    tick();
    check("dn a1", bus8.addr, 8'hFF);
    check("dn l1", bus8.last, 1'b0);
    tick();
    check("dn a2", bus8.addr, 8'hFC);
    check("dn l2", bus8.last, 1'b1);
    tick();
    check("dn valid", bus8.addr_valid, 1'b0);
    check("dn done",  done8, 1'b1);
    tick();
    check("dn busy", busy8, 1'b0);
    check("dn done2", done8, 1'b0);

    // ---- zero length, start held through DONE, restart
    base = 32'h40; len = 32'd0; step = 8'd4; dir = 1'b0; cont = 1'b0;
    bus32.addr_ready = 1'b1; start = 1'b1;
    tick();
    check("z done",  done, 1'b1);
    check("z valid", bus32.addr_valid, 1'b0);
    check("z busy",  busy, 1'b1);
    len = 32'd2;
    tick();
    check("z2 done",  done, 1'b0);
    check("z2 valid", bus32.addr_valid, 1'b0);
    check("z2 busy",  busy, 1'b0);
    tick();
    start = 1'b0;
    check("z3 valid", bus32.addr_valid, 1'b1);
    check("z3 addr",  bus32.addr, 32'h40);
    tick();
    check("z4 addr", bus32.addr, 32'h44);
    check("z4 last", bus32.last, 1'b1);
    tick();
    check("z5 done", done, 1'b1);
    tick();

    // ---- continuous mode, then abort
    base = 32'h100; step = 8'd1; len = 32'd3; cont = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("c0 addr", bus32.addr, 32'h100);
    check("c0 wrap", wrap, 1'b0);
    tick();
    check("c1 addr", bus32.addr, 32'h101);
    tick();
    check("c2 addr", bus32.addr, 32'h102);
    check("c2 last", bus32.last, 1'b1);
    tick();
    check("c3 addr", bus32.addr, 32'h100);
    check("c3 wrap", wrap, 1'b1);
    check("c3 idx",  bus32.idx, 32'h0);
    tick();
    check("c4 addr", bus32.addr, 32'h101);
    check("c4 wrap", wrap, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_quiet("cab");
    check("cab addr", bus32.addr, 32'h101);
    check("cab idx",  bus32.idx,  32'h1);
    tick();
    chk_quiet("cab2");

    // ---- abort coinciding with the final transfer
    base = 32'h200; len = 32'd2; cont = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("af last", bus32.last, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_quiet("af");
    tick();
    chk_quiet("af2");

    // ---- start together with abort in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk_quiet("sa");

    // ---- randomized traffic vs reference model
    ph = 0; pos = 0; mb = '0; ml = '0; ms = '0;
    md = 1'b0; mc = 1'b0; mw = 1'b0;
    for (int n = 0; n < 800; n++) begin
      CE = ($urandom_range(0, 9) < 8);
      bus32.addr_ready = ($urandom_range(0, 9) < 7);
      abort = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 2) == 0);
      base = $urandom;
      len = 32'($urandom_range(0, 5));
      step = 8'($urandom);
      dir = 1'($urandom);
      cont = ($urandom_range(0, 3) == 0);
      tick();
      if (CE) begin
        if (abort) begin
          ph = 0; mw = 1'b0;
        end else if (ph == 0) begin
          mw = 1'b0;
          if (start) begin
            mb = base; ml = len; ms = step; md = dir; mc = cont;
            pos = 0;
            ph = (len == 0) ? 2 : 1;
          end
        end else if (ph == 1) begin
          mw = 1'b0;
          if (bus32.addr_ready) begin
            if (pos == ml - 1) begin
              if (mc) begin
                pos = 0; mw = 1'b1;
              end else begin
                ph = 2;
              end
            end else begin
              pos++;
            end
          end
        end else begin
          ph = 0;
        end
      end
      check($sformatf("rnd%0d valid", n), bus32.addr_valid, ph == 1);
      check($sformatf("rnd%0d busy", n),  busy, ph != 0);
      check($sformatf("rnd%0d done", n),  done, ph == 2);
      check($sformatf("rnd%0d wrap", n),  wrap, mw);
      check($sformatf("rnd%0d last", n),  bus32.last,
            (ph == 1) && (pos == ml - 1));
      if (ph == 1) begin
        ea = md ? mb - 32'(pos * ms) : mb + 32'(pos * ms);
        check($sformatf("rnd%0d addr", n), bus32.addr, ea);
        check($sformatf("rnd%0d idx", n),  bus32.idx, 32'(pos));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
